// File: rtl/tug_of_war_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tug_of_war_ctrl_pkg
//  Description : Shared state encoding and score width for the tug-of-war
//                game controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package tug_of_war_ctrl_pkg;

    localparam int c_SCORE_W = 3;

    typedef enum logic [1:0] {
        ST_PLAY       = 2'd0,
        ST_WIN_L      = 2'd1,
        ST_WIN_R      = 2'd2,
        ST_MATCH_OVER = 2'd3
    } state_t;

endpackage : tug_of_war_ctrl_pkg
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
//  Module      : key_edge
//  Description : Rising-edge detector for a synchronized key level. The
//                previous-level register resets to 1 so a key held through
//                reset does not produce a pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_edge (
    input  logic Clock,
    input  logic Reset,
    input  logic level,
    output logic pulse
);

    logic r_prev;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= level;
        end
    end

    assign pulse = level & ~r_prev;

endmodule : key_edge
`default_nettype wire

// File: rtl/tug_of_war_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tug_of_war_ctrl
//  Description : Game controller for a tug-of-war light row: key edge
//                detection, round win detection, score keeping, winner
//                display timing and match termination.
//  Revision    : 1.0 - initial release
// ============================================================================
module tug_of_war_ctrl
    import tug_of_war_ctrl_pkg::*;
#(
    parameter int NUM_LIGHTS  = 9,
    parameter int MAX_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  L,
    input  logic                  R,
    input  logic [NUM_LIGHTS-1:0] lights,
    output logic                  Lp,
    output logic                  Rp,
    output logic                  next,
    output logic [c_SCORE_W-1:0]  leftScore,
    output logic [c_SCORE_W-1:0]  rightScore,
    output logic                  roundOver,
    output logic                  leftWins,
    output logic                  rightWins
);

    localparam int                   c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_SCORE_W-1:0] c_MAX = c_SCORE_W'(MAX_SCORE);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_HOLD_W-1:0]   r_hold;
    logic [c_SCORE_W-1:0]  r_left_score;
    logic [c_SCORE_W-1:0]  r_right_score;
    logic                  w_l_raw;
    logic                  w_r_raw;
    logic                  w_win_l;
    logic                  w_win_r;
    logic                  w_hold_last;
    logic                  w_in_win;

    // Only the two end lights decide a round.
    logic w_unused_lights;
    assign w_unused_lights = ^lights;

    key_edge u_key_edge_l (
        .Clock (Clock),
        .Reset (Reset),
        .level (L),
        .pulse (w_l_raw)
    );

    key_edge u_key_edge_r (
        .Clock (Clock),
        .Reset (Reset),
        .level (R),
        .pulse (w_r_raw)
    );

    assign w_hold_last = (r_hold == c_HOLD_LAST);
    assign w_in_win    = (r_state == ST_WIN_L) || (r_state == ST_WIN_R);

    always_comb begin
        w_state_nxt = r_state;
        Lp          = 1'b0;
        Rp          = 1'b0;
        next        = 1'b0;
        roundOver   = 1'b0;
        w_win_l     = 1'b0;
        w_win_r     = 1'b0;
        unique case (r_state)
            ST_PLAY: begin
                Lp = w_l_raw;
                Rp = w_r_raw;
                if (w_l_raw && !w_r_raw && lights[NUM_LIGHTS-1]) begin
                    w_win_l     = 1'b1;
                    w_state_nxt = ST_WIN_L;
                end else if (w_r_raw && !w_l_raw && lights[0]) begin
                    w_win_r     = 1'b1;
                    w_state_nxt = ST_WIN_R;
                end
            end
            ST_WIN_L: begin
                roundOver = 1'b1;
                if (w_hold_last) begin
                    // Light cells reset themselves, so no restart pulse under Reset.
                    next        = ~Reset;
                    w_state_nxt = (r_left_score == c_MAX) ? ST_MATCH_OVER : ST_PLAY;
                end
            end
            ST_WIN_R: begin
                roundOver = 1'b1;
                if (w_hold_last) begin
                    next        = ~Reset;
                    w_state_nxt = (r_right_score == c_MAX) ? ST_MATCH_OVER : ST_PLAY;
                end
            end
            ST_MATCH_OVER: begin
                w_state_nxt = ST_MATCH_OVER;
            end
            default: begin
                w_state_nxt = ST_PLAY;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= ST_PLAY;
            r_hold        <= '0;
            r_left_score  <= '0;
            r_right_score <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_win_l || w_win_r) begin
                r_hold <= '0;
            end else if (w_in_win && !w_hold_last) begin
                r_hold <= r_hold + c_HOLD_W'(1);
            end
            if (w_win_l && (r_left_score != c_MAX)) begin
                r_left_score <= r_left_score + c_SCORE_W'(1);
            end
            if (w_win_r && (r_right_score != c_MAX)) begin
                r_right_score <= r_right_score + c_SCORE_W'(1);
            end
        end
    end

    assign leftScore  = r_left_score;
    assign rightScore = r_right_score;
    assign leftWins   = (r_state == ST_MATCH_OVER) && (r_left_score == c_MAX);
    assign rightWins  = (r_state == ST_MATCH_OVER) && (r_right_score == c_MAX);

endmodule : tug_of_war_ctrl
`default_nettype wire

// File: tb/tb_tug_of_war_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tug_of_war_ctrl
//  Description : Directed self-checking bench for tug_of_war_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tug_of_war_ctrl;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       L = 1'b0;
    logic       R = 1'b0;
    logic [8:0] lights = 9'b000010000;
    logic       Lp, Rp, next, roundOver, leftWins, rightWins;
    logic [2:0] leftScore, rightScore;

    int total = 0;
    int bad   = 0;

    tug_of_war_ctrl #(
        .NUM_LIGHTS  (9),
        .MAX_SCORE   (7),
        .HOLD_CYCLES (4)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .L          (L),
        .R          (R),
        .lights     (lights),
        .Lp         (Lp),
        .Rp         (Rp),
        .next       (next),
        .leftScore  (leftScore),
        .rightScore (rightScore),
        .roundOver  (roundOver),
        .leftWins   (leftWins),
        .rightWins  (rightWins)
    );

    always #5 Clock = ~Clock;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        L = 1'b0;
        R = 1'b0;
        cyc();
        cyc();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({leftScore, rightScore} !== 6'd0) begin
            bad++; $display("FAIL reset_scores: got L=%0d R=%0d want 0 0", leftScore, rightScore);
        end
        total++;
        if ({roundOver, leftWins, rightWins, next, Lp, Rp} !== 6'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 000000", {roundOver, leftWins, rightWins, next, Lp, Rp});
        end
    endtask

    task automatic test_held_key();
        int lp_count;
        lights = 9'b000010000;
        lp_count = 0;
        cyc(); L = 1'b1; #1;
        if (Lp === 1'b1) lp_count++;
        total++;
        if (Rp !== 1'b0) begin
            bad++; $display("FAIL held_rp: got %b want 0", Rp);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            if (Lp === 1'b1) lp_count++;
        end
        total++;
        if (lp_count !== 1) begin
            bad++; $display("FAIL held_lp_count: got %0d want 1", lp_count);
        end
        total++;
        if (roundOver !== 1'b0 || leftScore !== 3'd0) begin
            bad++; $display("FAIL held_nostate: got roundOver=%b leftScore=%0d want 0 0", roundOver, leftScore);
        end
        cyc(); L = 1'b0; #1;
    endtask

    task automatic test_left_win();
        logic [3:0] next_seen;
        lights = 9'b100000000;
        cyc(); L = 1'b1; #1;
        total++;
        if (Lp !== 1'b1 || roundOver !== 1'b0) begin
            bad++; $display("FAIL lwin_press: got Lp=%b roundOver=%b want 1 0", Lp, roundOver);
        end
        cyc(); L = 1'b0; #1;
        total++;
        if (roundOver !== 1'b1 || leftScore !== 3'd1) begin
            bad++; $display("FAIL lwin_enter: got roundOver=%b leftScore=%0d want 1 1", roundOver, leftScore);
        end
        next_seen[0] = next;
        for (int i = 1; i < 4; i++) begin
            cyc(); #1;
            next_seen[i] = next;
            total++;
            if (roundOver !== 1'b1) begin
                bad++; $display("FAIL lwin_round_over_%0d: got %b want 1", i, roundOver);
            end
        end
        total++;
        if (next_seen !== 4'b1000) begin
            bad++; $display("FAIL lwin_next_timing: got %b want 1000", next_seen);
        end
        cyc(); #1;
        total++;
        if (roundOver !== 1'b0 || next !== 1'b0 || leftScore !== 3'd1) begin
            bad++; $display("FAIL lwin_back_play: got roundOver=%b next=%b leftScore=%0d want 0 0 1", roundOver, next, leftScore);
        end
    endtask

    task automatic test_simultaneous();
        lights = 9'b000000001;
        cyc(); L = 1'b1; R = 1'b1; #1;
        total++;
        if (Lp !== 1'b1 || Rp !== 1'b1) begin
            bad++; $display("FAIL simul_pulses: got Lp=%b Rp=%b want 1 1", Lp, Rp);
        end
        cyc(); L = 1'b0; R = 1'b0; #1;
        total++;
        if (roundOver !== 1'b0 || leftScore !== 3'd1 || rightScore !== 3'd0) begin
            bad++; $display("FAIL simul_nowin: got roundOver=%b L=%0d R=%0d want 0 1 0", roundOver, leftScore, rightScore);
        end
    endtask

    task automatic test_right_match();
        lights = 9'b000000001;
        for (int i = 0; i < 7; i++) begin
            cyc(); R = 1'b1; #1;
            total++;
            if (Rp !== 1'b1) begin
                bad++; $display("FAIL rmatch_press_%0d: got Rp=%b want 1", i, Rp);
            end
            cyc(); R = 1'b0; #1;
            total++;
            if (rightScore !== 3'(i + 1)) begin
                bad++; $display("FAIL rmatch_score_%0d: got %0d want %0d", i, rightScore, i + 1);
            end
            cyc(); cyc(); cyc();
        end
        cyc(); #1;
        total++;
        if (rightWins !== 1'b1 || leftWins !== 1'b0 || rightScore !== 3'd7 || roundOver !== 1'b0) begin
            bad++; $display("FAIL rmatch_over: got rW=%b lW=%b R=%0d ro=%b want 1 0 7 0", rightWins, leftWins, rightScore, roundOver);
        end
        lights = 9'b100000001;
        for (int i = 0; i < 3; i++) begin
            cyc(); L = 1'b1; R = (i != 1); #1;
            total++;
            if (Lp !== 1'b0 || Rp !== 1'b0 || next !== 1'b0) begin
                bad++; $display("FAIL rmatch_ignore_%0d: got Lp=%b Rp=%b next=%b want 0 0 0", i, Lp, Rp, next);
            end
            cyc(); L = 1'b0; R = 1'b0; #1;
        end
        total++;
        if (rightScore !== 3'd7 || leftScore !== 3'd1 || rightWins !== 1'b1) begin
            bad++; $display("FAIL rmatch_frozen: got R=%0d L=%0d rW=%b want 7 1 1", rightScore, leftScore, rightWins);
        end
    endtask

    task automatic test_reset_mid_win();
        do_reset();
        lights = 9'b100000000;
        cyc(); L = 1'b1; #1;
        cyc(); L = 1'b0; #1;
        cyc(); Reset = 1'b1; #1;
        total++;
        if (next !== 1'b0 || roundOver !== 1'b1) begin
            bad++; $display("FAIL rstmid_win2: got next=%b roundOver=%b want 0 1", next, roundOver);
        end
        cyc(); Reset = 1'b0; #1;
        total++;
        if (roundOver !== 1'b0 || leftScore !== 3'd0 || next !== 1'b0) begin
            bad++; $display("FAIL rstmid_play: got ro=%b L=%0d next=%b want 0 0 0", roundOver, leftScore, next);
        end
        // Reset landing on the final display cycle must also suppress the restart pulse.
        cyc(); L = 1'b1; #1;
        cyc(); L = 1'b0; #1;
        cyc(); cyc(); cyc(); Reset = 1'b1; #1;
        total++;
        if (next !== 1'b0 || roundOver !== 1'b1) begin
            bad++; $display("FAIL rstmid_last: got next=%b roundOver=%b want 0 1", next, roundOver);
        end
        cyc(); Reset = 1'b0; #1;
        total++;
        if (roundOver !== 1'b0 || leftScore !== 3'd0) begin
            bad++; $display("FAIL rstmid_last_play: got ro=%b L=%0d want 0 0", roundOver, leftScore);
        end
    endtask

    task automatic test_held_across_restart();
        int lp_count;
        do_reset();
        lights = 9'b100000000;
        cyc(); L = 1'b1; #1;
        cyc(); #1;
        cyc(); cyc(); cyc(); #1;
        lp_count = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            if (Lp === 1'b1) lp_count++;
        end
        total++;
        if (lp_count !== 0 || roundOver !== 1'b0 || leftScore !== 3'd1) begin
            bad++; $display("FAIL held_restart: got Lp_count=%0d ro=%b L=%0d want 0 0 1", lp_count, roundOver, leftScore);
        end
        cyc(); L = 1'b0; #1;
        cyc(); L = 1'b1; #1;
        total++;
        if (Lp !== 1'b1) begin
            bad++; $display("FAIL held_repress: got Lp=%b want 1", Lp);
        end
        cyc(); L = 1'b0; #1;
        total++;
        if (leftScore !== 3'd2 || roundOver !== 1'b1) begin
            bad++; $display("FAIL held_second_win: got L=%0d ro=%b want 2 1", leftScore, roundOver);
        end
    endtask

    initial begin
        test_reset();
        test_held_key();
        test_left_win();
        test_simultaneous();
        test_right_match();
        test_reset_mid_win();
        test_held_across_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_tug_of_war_ctrl
`default_nettype wire
